// File: rtl/msdap_feeder_pkg.sv
// Shared parameters, state encoding and coefficient-entry layout for the MSDAP
// sample/coefficient feeder.
package msdap_feeder_pkg;

   localparam int DATA_W  = 16;
   localparam int HIST    = 256;
   localparam int NCOEF   = 512;
   localparam int NRJ     = 16;

   localparam int HIST_AW = $clog2(HIST);
   localparam int COEF_AW = $clog2(NCOEF);
   localparam int RJ_AW   = $clog2(NRJ);
   localparam int CNT_W   = HIST_AW + 1;

   // Coefficient entry: {sign, delay k}
   localparam int COEF_W   = 9;
   localparam int SIGN_BIT = 8;
   localparam int K_MSB    = 7;

   localparam int RJ_W = 8;
   localparam int CT_W = 11;

   typedef enum logic [2:0] {
      IDLE,
      COEF,
      DATA,
      PRESENT,
      WAIT_DONE
   } state_e;

endpackage

// File: rtl/msdap_sp_ram.sv
// Single-port RAM with registered read; used for the sample history and the
// coefficient table.
module msdap_sp_ram #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 256
) (
   input  logic                     clk,
   input  logic                     we_i,
   input  logic                     re_i,
   input  logic [$clog2(DEPTH)-1:0] addr_i,
   input  logic [WIDTH-1:0]         wdata_i,
   output logic [WIDTH-1:0]         rdata_o
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] rdata_q;

   // NOTE: storage arrays carry no reset so they map onto RAM macros; the
   // feeder's n_cnt makes stale history contents unobservable.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem[addr_i] <= wdata_i;
      end
      if (re_i) begin
         rdata_q <= mem[addr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/msdap_feeder.sv
// Walks the coefficient table for each accepted sample and presents
// {x[n-k], sign} to the MSDAP core, one transfer per core request.
module msdap_feeder
   import msdap_feeder_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               cfg_we,
   input  logic               cfg_sel,
   input  logic [COEF_AW-1:0] cfg_addr,
   input  logic [COEF_W-1:0]  cfg_wdata,
   output logic               cfg_err,
   input  logic               smp_valid,
   input  logic [DATA_W-1:0]  smp_data,
   output logic               smp_ready,
   input  logic               core_req,
   output logic               out_valid,
   output logic [DATA_W-1:0]  out_data,
   output logic               out_sign,
   input  logic               core_done,
   output logic               frame_done,
   output logic               busy
);

   state_e               state_q;
   logic [HIST_AW-1:0]   wptr_q;
   logic [CNT_W-1:0]     n_cnt_q;
   logic [COEF_AW-1:0]   coef_idx_q;
   logic [CT_W-1:0]      coef_total_q;
   logic [RJ_W-1:0]      rj_q [NRJ];
   logic                 cfg_err_q;
   logic                 out_valid_q;
   logic                 frame_done_q;
   logic                 zero_q;
   logic                 sign_q;

   logic [COEF_W-1:0]    coef_rdata;
   logic [DATA_W-1:0]    hist_rdata;
   logic [K_MSB:0]       coef_k;
   logic [HIST_AW-1:0]   hist_rd_addr;
   logic [HIST_AW-1:0]   hist_addr;
   logic [COEF_AW-1:0]   coef_addr;
   logic                 accept;
   logic                 transfer;
   logic                 cfg_ok;
   logic                 last_coef;

   assign smp_ready  = (state_q == IDLE) && !cfg_err_q;
   assign accept     = smp_valid && smp_ready;
   assign transfer   = out_valid_q && core_req;
   assign cfg_ok     = cfg_we && (state_q == IDLE);
   assign last_coef  = (CT_W'(coef_idx_q) == (coef_total_q - CT_W'(1)));

   assign coef_k       = coef_rdata[K_MSB:0];
   assign hist_rd_addr = wptr_q - HIST_AW'(1) - coef_k;

   // Both RAMs are single-ported: IDLE owns them for writes, the walk for reads.
   assign hist_addr = (state_q == IDLE) ? wptr_q : hist_rd_addr;
   assign coef_addr = (state_q == IDLE) ? cfg_addr : coef_idx_q;

   msdap_sp_ram #(.WIDTH(DATA_W), .DEPTH(HIST)) u_hist (
      .clk     (clk),
      .we_i    (accept),
      .re_i    (state_q == DATA),
      .addr_i  (hist_addr),
      .wdata_i (smp_data),
      .rdata_o (hist_rdata)
   );

   msdap_sp_ram #(.WIDTH(COEF_W), .DEPTH(NCOEF)) u_coef (
      .clk     (clk),
      .we_i    (cfg_ok && !cfg_sel),
      .re_i    (state_q == COEF),
      .addr_i  (coef_addr),
      .wdata_i (cfg_wdata),
      .rdata_o (coef_rdata)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         wptr_q       <= '0;
         n_cnt_q      <= '0;
         coef_idx_q   <= '0;
         out_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
         zero_q       <= 1'b0;
         sign_q       <= 1'b0;
      end else begin
         frame_done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (accept) begin
                  wptr_q     <= wptr_q + HIST_AW'(1);
                  n_cnt_q    <= (n_cnt_q == CNT_W'(HIST)) ? n_cnt_q : n_cnt_q + CNT_W'(1);
                  coef_idx_q <= '0;
                  if (coef_total_q != '0) begin
                     state_q <= COEF;
                  end else begin
                     frame_done_q <= 1'b1;
                  end
               end
            end
            COEF: begin
               state_q <= DATA;
            end
            DATA: begin
               // Delays reaching past the oldest stored sample read as zero.
               zero_q      <= (CNT_W'(coef_k) >= n_cnt_q);
               sign_q      <= coef_rdata[SIGN_BIT];
               out_valid_q <= 1'b1;
               state_q     <= PRESENT;
            end
            PRESENT: begin
               if (transfer) begin
                  out_valid_q <= 1'b0;
                  coef_idx_q  <= coef_idx_q + COEF_AW'(1);
                  state_q     <= last_coef ? WAIT_DONE : COEF;
               end
            end
            WAIT_DONE: begin
               if (core_done) begin
                  frame_done_q <= 1'b1;
                  state_q      <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // r_j table, running coefficient total and the sticky configuration error.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int j = 0; j < NRJ; j++) begin
            rj_q[j] <= '0;
         end
         coef_total_q <= '0;
         cfg_err_q    <= 1'b0;
      end else begin
         if (cfg_ok && cfg_sel) begin
            rj_q[cfg_addr[RJ_AW-1:0]] <= cfg_wdata[RJ_W-1:0];
            coef_total_q <= coef_total_q - CT_W'(rj_q[cfg_addr[RJ_AW-1:0]])
                            + CT_W'(cfg_wdata[RJ_W-1:0]);
         end
         if ((cfg_we && (state_q != IDLE)) || (coef_total_q > CT_W'(NCOEF))) begin
            cfg_err_q <= 1'b1;
         end
      end
   end

   assign cfg_err    = cfg_err_q;
   assign out_valid  = out_valid_q;
   assign out_data   = (out_valid_q && !zero_q) ? hist_rdata : '0;
   assign out_sign   = sign_q;
   assign frame_done = frame_done_q;
   assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_msdap_feeder.sv
// Scoreboard bench for msdap_feeder: stimulus pushes expected transfers, a
// negedge monitor pops and compares every transfer the DUT makes.
module tb_msdap_feeder;
   import msdap_feeder_pkg::*;

   logic               clk = 1'b0;
   logic               reset = 1'b1;
   logic               cfg_we = 1'b0;
   logic               cfg_sel = 1'b0;
   logic [COEF_AW-1:0] cfg_addr = '0;
   logic [COEF_W-1:0]  cfg_wdata = '0;
   logic               cfg_err;
   logic               smp_valid = 1'b0;
   logic [DATA_W-1:0]  smp_data = '0;
   logic               smp_ready;
   logic               core_req = 1'b1;
   logic               out_valid;
   logic [DATA_W-1:0]  out_data;
   logic               out_sign;
   logic               core_done = 1'b0;
   logic               frame_done;
   logic               busy;

   always #5 clk = ~clk;

   msdap_feeder dut (
      .clk        (clk),
      .reset      (reset),
      .cfg_we     (cfg_we),
      .cfg_sel    (cfg_sel),
      .cfg_addr   (cfg_addr),
      .cfg_wdata  (cfg_wdata),
      .cfg_err    (cfg_err),
      .smp_valid  (smp_valid),
      .smp_data   (smp_data),
      .smp_ready  (smp_ready),
      .core_req   (core_req),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_sign   (out_sign),
      .core_done  (core_done),
      .frame_done (frame_done),
      .busy       (busy)
   );

   typedef struct packed {
      logic [DATA_W-1:0] d;
      logic              s;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   checks   = 0;
   int   failures = 0;
   int   xfers    = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   // A transfer happens at the next rising edge when valid and req are both high.
   always @(negedge clk) begin
      if (!reset && out_valid === 1'b1 && core_req === 1'b1) begin
         xfers++;
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_xfer: actual data=0x%0h required=no transfer", out_data);
         end else begin
            mon_e = sb.pop_front();
            check("xfer_data", 32'(out_data), 32'(mon_e.d));
            check("xfer_sign", 32'(out_sign), 32'(mon_e.s));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      sb.delete();
      tick();
      tick();
      reset = 1'b0;
      tick();
   endtask

   task automatic cfg_write(input logic sel, input logic [8:0] addr, input logic [8:0] data);
      cfg_we = 1'b1; cfg_sel = sel; cfg_addr = addr; cfg_wdata = data;
      tick();
      cfg_we = 1'b0;
   endtask

   task automatic load_delay_table();
      cfg_write(1'b1, 9'd0, 9'd3);
      cfg_write(1'b0, 9'd0, 9'h000);
      cfg_write(1'b0, 9'd1, 9'h101);
      cfg_write(1'b0, 9'd2, 9'h002);
   endtask

   task automatic push_exp(input logic [15:0] d, input logic s);
      sb.push_back('{d: d, s: s});
   endtask

   // Returns one cycle after the acceptance edge.
   task automatic offer_sample(input logic [15:0] d);
      int n;
      n = 0;
      while (smp_ready !== 1'b1 && n < 100) begin
         tick();
         n++;
      end
      if (n >= 100) check("smp_ready_timeout", 32'(smp_ready), 32'd1);
      smp_valid = 1'b1; smp_data = d;
      tick();
      smp_valid = 1'b0;
   endtask

   task automatic wait_valid(input string tag);
      int w;
      w = 0;
      while (out_valid !== 1'b1 && w < 20) begin
         tick();
         w++;
      end
      check({tag, "_valid"}, 32'(out_valid), 32'd1);
   endtask

   task automatic finish_frame(input int start, input int n, input string tag);
      int w;
      w = 0;
      while (xfers < start + n && w < 200) begin
         tick();
         w++;
      end
      check({tag, "_xfer_count"}, 32'(xfers - start), 32'(n));
      core_done = 1'b1;
      tick();
      core_done = 1'b0;
      check({tag, "_frame_done"}, 32'(frame_done), 32'd1);
      tick();
      check({tag, "_frame_done_pulse"}, 32'(frame_done), 32'd0);
      check({tag, "_busy_after"}, 32'(busy), 32'd0);
      check({tag, "_sb_drained"}, 32'(sb.size()), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int start;
      int lat;
      int gap;

      // Reset values
      do_reset();
      check("rst_out_valid",  32'(out_valid),  32'd0);
      check("rst_frame_done", 32'(frame_done), 32'd0);
      check("rst_busy",       32'(busy),       32'd0);
      check("rst_cfg_err",    32'(cfg_err),    32'd0);
      check("rst_out_data",   32'(out_data),   32'd0);
      check("rst_out_sign",   32'(out_sign),   32'd0);
      check("rst_smp_ready",  32'(smp_ready),  32'd1);

      // Delay check: coefs {+,0} {-,1} {+,2}
      load_delay_table();
      push_exp(16'h0010, 1'b0); push_exp(16'h0000, 1'b1); push_exp(16'h0000, 1'b0);
      start = xfers;
      offer_sample(16'h0010);
      check("f1_busy", 32'(busy), 32'd1);
      check("f1_smp_ready", 32'(smp_ready), 32'd0);
      finish_frame(start, 3, "f1");
      push_exp(16'h0020, 1'b0); push_exp(16'h0010, 1'b1); push_exp(16'h0000, 1'b0);
      start = xfers;
      offer_sample(16'h0020);
      finish_frame(start, 3, "f2");

      // Handshake: latency, stall stability, 2-cycle gap
      core_req = 1'b0;
      push_exp(16'h0030, 1'b0); push_exp(16'h0020, 1'b1); push_exp(16'h0010, 1'b0);
      start = xfers;
      offer_sample(16'h0030);
      lat = 0;
      while (out_valid !== 1'b1 && lat < 10) begin
         tick();
         lat++;
      end
      check("hs_latency", 32'(lat), 32'd2);
      for (int i = 0; i < 5; i++) begin
         check("hs_stall_valid", 32'(out_valid), 32'd1);
         check("hs_stall_data",  32'(out_data),  32'h0030);
         check("hs_stall_sign",  32'(out_sign),  32'd0);
         tick();
      end
      core_req = 1'b1;
      tick();
      gap = 0;
      while (out_valid !== 1'b1 && gap < 10) begin
         gap++;
         tick();
      end
      check("hs_gap", 32'(gap), 32'd2);
      finish_frame(start, 3, "hs");

      // Config write during PRESENT is dropped and flags cfg_err
      core_req = 1'b0;
      push_exp(16'h0040, 1'b0); push_exp(16'h0030, 1'b1); push_exp(16'h0020, 1'b0);
      start = xfers;
      offer_sample(16'h0040);
      wait_valid("busy_wr");
      cfg_write(1'b1, 9'd0, 9'd1);
      check("busy_wr_cfg_err", 32'(cfg_err), 32'd1);
      core_req = 1'b1;
      finish_frame(start, 3, "busy_wr");
      check("busy_wr_smp_ready", 32'(smp_ready), 32'd0);

      // Coefficient total limit
      do_reset();
      for (int j = 0; j < NRJ; j++) cfg_write(1'b1, 9'(j), 9'h020);
      tick();
      check("cfg512_err", 32'(cfg_err), 32'd0);
      check("cfg512_ready", 32'(smp_ready), 32'd1);
      cfg_write(1'b1, 9'd0, 9'h021);
      tick();
      check("cfg513_err", 32'(cfg_err), 32'd1);
      check("cfg513_ready", 32'(smp_ready), 32'd0);

      // Empty table, then history wrap with k = 255
      do_reset();
      start = xfers;
      offer_sample(16'h0000);
      check("empty_frame_done", 32'(frame_done), 32'd1);
      check("empty_busy", 32'(busy), 32'd0);
      check("empty_out_valid", 32'(out_valid), 32'd0);
      for (int i = 1; i < 299; i++) begin
         offer_sample(16'(i));
         if (frame_done !== 1'b1) check("empty_loop_frame_done", 32'(frame_done), 32'd1);
      end
      check("empty_no_xfers", 32'(xfers - start), 32'd0);
      cfg_write(1'b1, 9'd0, 9'd1);
      cfg_write(1'b0, 9'd0, 9'h0FF);
      push_exp(16'h002C, 1'b0);
      start = xfers;
      offer_sample(16'd299);
      finish_frame(start, 1, "wrap");

      // Reset asserted in PRESENT
      cfg_write(1'b1, 9'd0, 9'd3);
      load_delay_table();
      core_req = 1'b0;
      push_exp(16'h0055, 1'b0);
      offer_sample(16'h0055);
      wait_valid("midrst");
      #1 reset = 1'b1;
      #1;
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_out_data", 32'(out_data), 32'd0);
      sb.delete();
      tick();
      tick();
      reset = 1'b0;
      tick();
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_ready", 32'(smp_ready), 32'd1);
      load_delay_table();
      core_req = 1'b1;
      push_exp(16'h0077, 1'b0); push_exp(16'h0000, 1'b1); push_exp(16'h0000, 1'b0);
      start = xfers;
      offer_sample(16'h0077);
      finish_frame(start, 3, "postrst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
